// File: rtl/d_ff_rst_pkg.sv
// Shared constants for the d_ff_rst register cell.
// Kept in a package so wrappers and shift chains can pick up the same default width.
package d_ff_rst_pkg;

  localparam int unsigned DefaultWidth = 1;

endpackage

// File: rtl/d_ff_rst.sv
// Edge-triggered D register with asynchronous, active-high reset to RESET_VALUE.
// Leaf storage cell for pipelines, synchronisers and state registers.
module d_ff_rst
  import d_ff_rst_pkg::*;
#(
  parameter int unsigned       WIDTH       = DefaultWidth,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset branch first so a coincident rst rise and clk edge always resolves to RESET_VALUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_d_ff_rst.sv
// Bench for d_ff_rst: a 1-bit default instance and an 8-bit instance with reset value A5.
// Expected values come from a vector table and a small scoreboard queue.
module tb_d_ff_rst;

  logic       clk;
  logic       rst_n1;
  logic       d_n1;
  logic       q_n1;
  logic       rst_w;
  logic [7:0] d_w;
  logic [7:0] q_w;

  d_ff_rst u_dut_narrow (
    .clk (clk),
    .rst (rst_n1),
    .d   (d_n1),
    .q   (q_n1)
  );

  d_ff_rst #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) u_dut_wide (
    .clk (clk),
    .rst (rst_w),
    .d   (d_w),
    .q   (q_w)
  );

  // Rising edges at 50, 150, 250, ...
  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    logic rst;
    logic d;
    logic q;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  vec_t vecs[9];
  sb_t  sb_q[$];
  int   n_total;
  int   n_pass;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, required %h at t=%0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic sb_push(input string name, input logic [7:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [7:0] act);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_empty: got %h, required an expected entry at t=%0t", act, $time);
    end else begin
      e = sb_q.pop_front();
      check(e.name, act, e.exp);
    end
  endtask

  initial begin
    logic prev_q;
    logic [7:0] rv;
    n_total = 0;
    n_pass  = 0;

    // {rst, d, expected q after the following edge}
    vecs[0] = '{rst: 1'b1, d: 1'b0, q: 1'b0};
    vecs[1] = '{rst: 1'b1, d: 1'b1, q: 1'b0};
    vecs[2] = '{rst: 1'b1, d: 1'b0, q: 1'b0};
    vecs[3] = '{rst: 1'b0, d: 1'b0, q: 1'b0};
    vecs[4] = '{rst: 1'b0, d: 1'b1, q: 1'b1};
    vecs[5] = '{rst: 1'b0, d: 1'b0, q: 1'b0};
    vecs[6] = '{rst: 1'b0, d: 1'b1, q: 1'b1};
    vecs[7] = '{rst: 1'b0, d: 1'b0, q: 1'b0};
    vecs[8] = '{rst: 1'b0, d: 1'b1, q: 1'b1};

    rst_n1 = 1'b1;
    d_n1   = 1'b1;
    rst_w  = 1'b1;
    d_w    = 8'h5A;
    prev_q = 1'b0;

    #25;
    for (int i = 0; i < 9; i++) begin
      // t = 25 + 100*i
      rst_n1 = vecs[i].rst;
      d_n1   = vecs[i].d;
      sb_push($sformatf("vec%0d_after_edge", i), {7'd0, vecs[i].q});
      #15;
      if (i > 0) check($sformatf("vec%0d_hold_before_edge", i), {7'd0, q_n1}, {7'd0, prev_q});
      #20;
      sb_check({7'd0, q_n1});
      prev_q = vecs[i].q;
      if (i != 8) #65;
    end

    // t = 860: q=1, d=1; async reset mid-cycle
    rst_n1 = 1'b1;
    #1;
    check("async_reset_immediate", {7'd0, q_n1}, 8'h00);
    #99;
    check("async_reset_holds_over_edge", {7'd0, q_n1}, 8'h00);
    #65;
    rst_n1 = 1'b0;
    d_n1   = 1'b1;
    #35;
    check("capture_after_release", {7'd0, q_n1}, 8'h01);

    // Reset rising exactly on a clk edge with d=1 must still give 0
    @(posedge clk);
    rst_n1 = 1'b1;
    #10;
    check("reset_wins_on_edge", {7'd0, q_n1}, 8'h00);
    #65;
    rst_n1 = 1'b0;

    // Wide instance: reset has been held since t=0 while clk ran
    check("wide_reset_value", q_w, 8'hA5);
    rst_w = 1'b0;
    d_w   = 8'h3C;
    sb_push("wide_capture_3c", 8'h3C);
    #15;
    check("wide_hold_before_edge", q_w, 8'hA5);
    #20;
    sb_check(q_w);

    for (int i = 0; i < 6; i++) begin
      #65;
      rv  = 8'($urandom_range(0, 255));
      d_w = rv;
      sb_push($sformatf("wide_rand%0d", i), rv);
      #35;
      sb_check(q_w);
    end

    #5;
    rst_w = 1'b1;
    #1;
    check("wide_async_reset", q_w, 8'hA5);
    @(posedge clk);
    #10;
    check("wide_reset_ignores_edge", q_w, 8'hA5);

    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
